// File: rtl/id_reorder_pkg.sv
// Shared types for the ID reorder buffer: per-slot lifecycle state and slot record.
// IDs are stored zero-extended to MAX_ID_WIDTH so the package stays width-agnostic.
package id_reorder_pkg;

  localparam int unsigned MAX_ID_WIDTH = 32;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_FILLED  = 2'd2
  } slot_state_e;

  typedef struct packed {
    slot_state_e             state;
    logic [MAX_ID_WIDTH-1:0] id;
  } slot_t;

endpackage

// File: rtl/id_reorder_oldest_match.sv
// Finds the first set bit of a match vector in circular order starting at head_i,
// i.e. the oldest matching slot of the reorder ring.
module id_reorder_oldest_match #(
  parameter int unsigned CAPACITY  = 8,
  parameter int unsigned IDX_WIDTH = (CAPACITY > 1) ? $clog2(CAPACITY) : 1
) (
  input  logic [CAPACITY-1:0]  match_i,
  input  logic [IDX_WIDTH-1:0] head_i,
  output logic                 found_o,
  output logic [IDX_WIDTH-1:0] idx_o
);

  logic [CAPACITY-1:0]  rotated;
  logic [IDX_WIDTH-1:0] offset;
  logic                 empty;
  int unsigned          j;
  int unsigned          sum;

  // Rotate so bit 0 is the head slot; a trailing-zero count then gives age order.
  always_comb begin
    rotated = '0;
    j       = 0;
    for (int unsigned i = 0; i < CAPACITY; i++) begin
      j = int'(head_i) + i;
      if (j >= CAPACITY) j = j - CAPACITY;
      rotated[i] = match_i[j];
    end
  end

  lzc #(
    .WIDTH    (CAPACITY),
    .MODE     (1'b0),
    .CNT_WIDTH(IDX_WIDTH)
  ) u_lzc (
    .in_i   (rotated),
    .cnt_o  (offset),
    .empty_o(empty)
  );

  always_comb begin
    sum = int'(head_i) + int'(offset);
    if (sum >= CAPACITY) sum = sum - CAPACITY;
    idx_o   = IDX_WIDTH'(sum);
    found_o = !empty;
  end

endmodule

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=0 counts trailing zeros, MODE=1 counts leading zeros.
// empty_o is set when no input bit is set; cnt_o is then zero.
module lzc #(
  parameter int unsigned WIDTH = 2,
  parameter bit          MODE  = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  int unsigned k;

  // Scan from lowest to highest priority so the last hit wins.
  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    k       = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      k = MODE ? i : (WIDTH - 1 - i);
      if (in_i[k]) begin
        cnt_o   = MODE ? CNT_WIDTH'(WIDTH - 1 - k) : CNT_WIDTH'(k);
        empty_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/id_reorder_buffer.sv
// Reorders out-of-order ID-tagged responses back into issue order.
// Slots are allocated at the tail, filled by oldest matching pending ID, and released at the head.
module id_reorder_buffer
  import id_reorder_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned CAPACITY = 8,
  parameter type         data_t   = logic [31:0]
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         alloc_req_i,
  input  logic [ID_WIDTH-1:0]          alloc_id_i,
  output logic                         alloc_gnt_o,
  input  logic                         rsp_valid_i,
  input  logic [ID_WIDTH-1:0]          rsp_id_i,
  input  data_t                        rsp_data_i,
  output logic                         rsp_ready_o,
  output logic                         rsp_err_o,
  output logic                         oup_valid_o,
  input  logic                         oup_ready_i,
  output logic [ID_WIDTH-1:0]          oup_id_o,
  output data_t                        oup_data_o,
  output logic [$clog2(CAPACITY+1)-1:0] count_o
);

  localparam int unsigned IDX_WIDTH = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam int unsigned CNT_WIDTH = $clog2(CAPACITY + 1);

  slot_t                slot_q [CAPACITY];
  data_t                data_q [CAPACITY];
  logic [IDX_WIDTH-1:0] head_q, tail_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 rsp_err_q;

  logic [CAPACITY-1:0]  match_vec;
  logic                 match_found;
  logic [IDX_WIDTH-1:0] match_idx;
  logic                 alloc_fire, rsp_fire, fill_en, pop_fire;

  function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] idx);
    if (idx == IDX_WIDTH'(CAPACITY - 1)) return '0;
    return idx + IDX_WIDTH'(1);
  endfunction

  // Match only against registered state, so a slot allocated this cycle cannot be hit.
  always_comb begin
    match_vec = '0;
    for (int unsigned i = 0; i < CAPACITY; i++) begin
      match_vec[i] = (slot_q[i].state == SLOT_PENDING) &&
                     (slot_q[i].id == MAX_ID_WIDTH'(rsp_id_i));
    end
  end

  id_reorder_oldest_match #(
    .CAPACITY (CAPACITY),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_oldest_match (
    .match_i(match_vec),
    .head_i (head_q),
    .found_o(match_found),
    .idx_o  (match_idx)
  );

  assign alloc_gnt_o = (count_q < CNT_WIDTH'(CAPACITY));
  assign rsp_ready_o = !rst_i;
  assign rsp_err_o   = rsp_err_q;
  assign count_o     = count_q;

  assign alloc_fire = alloc_req_i && alloc_gnt_o;
  assign rsp_fire   = rsp_valid_i && rsp_ready_o;
  assign fill_en    = rsp_fire && match_found;
  assign pop_fire   = oup_valid_o && oup_ready_i;

  always_comb begin
    oup_valid_o = (slot_q[head_q].state == SLOT_FILLED);
    oup_id_o    = '0;
    oup_data_o  = '0;
    if (oup_valid_o) begin
      oup_id_o   = slot_q[head_q].id[ID_WIDTH-1:0];
      oup_data_o = data_q[head_q];
    end
  end

  // Alloc (tail, FREE), fill (PENDING) and pop (head, FILLED) always target distinct slots.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < CAPACITY; i++) begin
        slot_q[i] <= '{state: SLOT_FREE, id: '0};
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (alloc_fire) begin
        slot_q[tail_q] <= '{state: SLOT_PENDING, id: MAX_ID_WIDTH'(alloc_id_i)};
        tail_q         <= next_idx(tail_q);
      end
      if (fill_en) begin
        slot_q[match_idx].state <= SLOT_FILLED;
      end
      if (pop_fire) begin
        slot_q[head_q].state <= SLOT_FREE;
        head_q               <= next_idx(head_q);
      end
      if (alloc_fire && !pop_fire) begin
        count_q <= count_q + CNT_WIDTH'(1);
      end else if (!alloc_fire && pop_fire) begin
        count_q <= count_q - CNT_WIDTH'(1);
      end
      rsp_err_q <= rsp_fire && !match_found;
    end
  end

  // Payload storage needs no reset: it is only observable once its slot is FILLED.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      data_q[match_idx] <= rsp_data_i;
    end
  end

endmodule

// File: tb/tb_id_reorder_buffer.sv
// Scoreboard bench for id_reorder_buffer: a queue-based issue-order model predicts
// released transactions, error pulses, occupancy and grant.
module tb_id_reorder_buffer;

  localparam int ID_W = 4;
  localparam int CAP  = 8;

  logic                      clk_i = 1'b0;
  logic                      rst_i = 1'b1;
  logic                      alloc_req_i = 1'b0;
  logic [ID_W-1:0]           alloc_id_i = '0;
  logic                      alloc_gnt_o;
  logic                      rsp_valid_i = 1'b0;
  logic [ID_W-1:0]           rsp_id_i = '0;
  logic [31:0]               rsp_data_i = '0;
  logic                      rsp_ready_o;
  logic                      rsp_err_o;
  logic                      oup_valid_o;
  logic                      oup_ready_i = 1'b0;
  logic [ID_W-1:0]           oup_id_o;
  logic [31:0]               oup_data_o;
  logic [$clog2(CAP+1)-1:0]  count_o;

  id_reorder_buffer #(
    .ID_WIDTH(ID_W),
    .CAPACITY(CAP),
    .data_t  (logic [31:0])
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .alloc_req_i(alloc_req_i),
    .alloc_id_i (alloc_id_i),
    .alloc_gnt_o(alloc_gnt_o),
    .rsp_valid_i(rsp_valid_i),
    .rsp_id_i   (rsp_id_i),
    .rsp_data_i (rsp_data_i),
    .rsp_ready_o(rsp_ready_o),
    .rsp_err_o  (rsp_err_o),
    .oup_valid_o(oup_valid_o),
    .oup_ready_i(oup_ready_i),
    .oup_id_o   (oup_id_o),
    .oup_data_o (oup_data_o),
    .count_o    (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    bit          filled;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          vis;
  } exp_t;

  ent_t pend[$];   // outstanding transactions in issue order, not yet releasable
  exp_t expq[$];   // releasable transactions in issue order, with first visible cycle
  bit   exp_err[int];
  int   n_alloc = 0;
  int   n_pop   = 0;
  int   cyc     = 0;
  bit   run     = 1'b0;
  int   checks  = 0;
  int   failures = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  // Monitor: compares the release port and error pulse against the scoreboard.
  always @(negedge clk_i) begin
    bit ev;
    if (run && !rst_i) begin
      ev = (expq.size() > 0) && (expq[0].vis <= cyc);
      chk("oup_valid", oup_valid_o, ev);
      chk("rsp_err", rsp_err_o, exp_err.exists(cyc));
      if (ev) begin
        chk("oup_id", oup_id_o, expq[0].id);
        chk("oup_data", oup_data_o, expq[0].data);
        if (oup_valid_o && oup_ready_i) begin
          void'(expq.pop_front());
          n_pop++;
        end
      end else begin
        chk("oup_id_idle", oup_id_o, 0);
        chk("oup_data_idle", oup_data_o, 0);
      end
    end
  end

  // One cycle of stimulus; called #1 after a rising edge.
  task automatic step(input bit a, input int aid, input bit r, input int rid,
                      input logic [31:0] rd, input bit ordy);
    int  mc;
    bit  found;
    mc = n_alloc - n_pop;
    chk("count", count_o, mc);
    chk("alloc_gnt", alloc_gnt_o, mc < CAP);
    alloc_req_i = a;
    alloc_id_i  = ID_W'(aid);
    rsp_valid_i = r;
    rsp_id_i    = ID_W'(rid);
    rsp_data_i  = rd;
    oup_ready_i = ordy;
    if (r) begin
      chk("rsp_ready", rsp_ready_o, 1);
      found = 1'b0;
      foreach (pend[k]) begin
        if (!found && !pend[k].filled && pend[k].id == rid) begin
          pend[k].filled = 1'b1;
          pend[k].data   = rd;
          found          = 1'b1;
        end
      end
      if (!found) exp_err[cyc+1] = 1'b1;
      while (pend.size() > 0 && pend[0].filled) begin
        expq.push_back('{id: pend[0].id, data: pend[0].data, vis: cyc + 1});
        void'(pend.pop_front());
      end
    end
    if (a && mc < CAP) begin
      pend.push_back('{id: aid, filled: 1'b0, data: '0});
      n_alloc++;
    end
    @(posedge clk_i);
    #1;
  endtask

  function automatic int pick_pending_id();
    int cand[$];
    foreach (pend[k]) if (!pend[k].filled) cand.push_back(pend[k].id);
    if (cand.size() == 0) return -1;
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  task automatic drain();
    int pid;
    for (int t = 0; t < 200 && (n_alloc != n_pop); t++) begin
      pid = pick_pending_id();
      if (pid >= 0) step(0, 0, 1, pid, $urandom, 1);
      else          step(0, 0, 0, 0, 0, 1);
    end
    step(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int pid;
    int rid;
    bit r;
    // Reset state
    #12;
    chk("rst_rsp_ready", rsp_ready_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_valid", oup_valid_o, 0);
    chk("rst_err", rsp_err_o, 0);
    chk("rst_oup_id", oup_id_o, 0);
    chk("rst_oup_data", oup_data_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    run   = 1'b1;
    @(posedge clk_i);
    #1;

    // Duplicate IDs release in issue order
    step(1, 3, 0, 0, 0, 1);
    step(1, 5, 0, 0, 0, 1);
    step(1, 3, 0, 0, 0, 1);
    step(0, 0, 1, 5, 32'hB, 1);
    step(0, 0, 1, 3, 32'hA1, 1);
    step(0, 0, 1, 3, 32'hA2, 1);
    repeat (4) step(0, 0, 0, 0, 0, 1);

    // Fill to capacity, stall the head, then pop while requesting
    for (int i = 0; i < CAP; i++) step(1, i, 0, 0, 0, 0);
    step(1, 9, 0, 0, 0, 0);
    step(0, 0, 1, 0, 32'h100, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    step(1, 9, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    for (int i = CAP - 1; i >= 1; i--) step(0, 0, 1, i, 32'h200 + i, 1);
    drain();

    // Response with nothing pending
    step(0, 0, 1, 7, 32'hDEAD, 1);
    repeat (2) step(0, 0, 0, 0, 0, 1);

    // Allocate and respond in the same cycle
    step(1, 2, 0, 0, 0, 1);
    step(1, 4, 1, 2, 32'h22, 1);
    step(1, 4, 1, 4, 32'h44, 0);
    step(0, 0, 1, 4, 32'h45, 1);
    drain();

    // Randomized traffic with wrap-around and duplicate IDs
    for (int t = 0; t < 400; t++) begin
      r   = ($urandom_range(0, 1) == 1);
      pid = pick_pending_id();
      rid = (pid >= 0 && $urandom_range(0, 4) != 0) ? pid : int'($urandom_range(0, 15));
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3), r, rid, $urandom,
           $urandom_range(0, 3) != 0);
    end
    drain();

    // Asynchronous reset with outstanding slots
    for (int i = 0; i < 4; i++) step(1, i + 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'h77, 0);
    step(0, 0, 0, 0, 0, 0);
    #2;
    rst_i = 1'b1;
    pend.delete();
    expq.delete();
    exp_err.delete();
    n_alloc = 0;
    n_pop   = 0;
    #1;
    chk("async_rst_valid", oup_valid_o, 0);
    chk("async_rst_count", count_o, 0);
    chk("async_rst_ready", rsp_ready_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 2, 32'h99, 1);
    repeat (3) step(0, 0, 0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_reorder_buffer.md
ID_REORDER_BUFFER -- requirements
Module: id_reorder_buffer

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, width of transaction ID.
REQ-002 SHALL have parameter CAPACITY, default 8, number of outstanding slots (>=1, not necessarily power of two).
REQ-003 SHALL have parameter type data_t, default logic[31:0], response payload.
REQ-004 SHALL have clk_i  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have alloc_req_i  input  1  request to allocate a slot in issue order.
REQ-007 SHALL have alloc_id_i  input  ID_WIDTH  ID of issued transaction.
REQ-008 SHALL have alloc_gnt_o  output  1  slot available; allocation occurs on req&&gnt.
REQ-009 SHALL have rsp_valid_i  input  1  out-of-order response present.
REQ-010 SHALL have rsp_id_i  input  ID_WIDTH  ID of response.
REQ-011 SHALL have rsp_data_i  input  data_t  response payload.
REQ-012 SHALL have rsp_ready_o  output  1  response accepted.
REQ-013 SHALL have rsp_err_o  output  1  one-cycle pulse: previous-cycle response had no pending match.
REQ-014 SHALL have oup_valid_o / oup_ready_i / oup_id_o / oup_data_o  out/in/out/out  1/1/ID_WIDTH/data_t  in-order release port.
REQ-015 SHALL have count_o  output  $clog2(CAPACITY+1)  occupied slots.

Function
REQ-016 Each slot SHALL be in state FREE, PENDING (ID recorded, no data) or FILLED (ID and data); head/tail pointers wrap CAPACITY-1 -> 0.
REQ-017 alloc_gnt_o SHALL equal (count < CAPACITY), from registered state only; no same-cycle bypass from a pop.
REQ-018 On alloc_req_i&&alloc_gnt_o the tail slot SHALL become PENDING with alloc_id_i next cycle; tail and count advance.
REQ-019 rsp_ready_o SHALL be 1 whenever not in reset; responses are never back-pressured.
REQ-020 An accepted response SHALL fill the oldest PENDING slot (circular search from head) whose ID equals rsp_id_i; slot becomes FILLED next cycle.
REQ-021 A response with no matching PENDING slot SHALL be dropped, state unchanged, rsp_err_o=1 next cycle only.
REQ-022 A slot allocated in cycle N SHALL NOT be matchable by a response in cycle N.
REQ-023 oup_valid_o SHALL equal (head slot FILLED); oup_id_o/oup_data_o reflect head slot, '0 when invalid.
REQ-024 Response-to-output latency SHALL be 1 cycle when the filled slot is head.
REQ-025 On oup_valid_o&&oup_ready_i head slot SHALL become FREE, head advances; oup_* held stable while valid&&!ready.
REQ-026 Simultaneous allocate and pop SHALL leave count unchanged; allocate, response and pop SHALL all be serviced in one cycle.
REQ-027 count_o SHALL be count register; never exceed CAPACITY or underflow.

Reset
REQ-028 While rst_i=1 all slots SHALL be FREE, head=tail=count=0 regardless of clock.
REQ-029 Reset values: alloc_gnt_o=1 (after deassert), rsp_ready_o=0 during reset, rsp_err_o=0, oup_valid_o=0, oup_id_o=0, oup_data_o=0, count_o=0.
REQ-030 Reset mid-operation SHALL discard all outstanding slots; no oup_valid_o or rsp_err_o in the first cycle after deassert.

Structure
REQ-031 Slot-state enum and slot struct SHALL live in package id_reorder_pkg.
REQ-032 Oldest-match search SHALL be sub-module id_reorder_oldest_match (match vector + head index -> found flag + index), using existing lzc.

Verification
REQ-033 Alloc IDs 3,5,3; responses 5(0xB),3(0xA1),3(0xA2) -> output order (3,0xA1),(5,0xB),(3,0xA2).
REQ-034 Fill CAPACITY=8 -> alloc_gnt_o=0, count_o=8; pop once with alloc_req_i=1 -> gnt stays 0 that cycle, 1 next.
REQ-035 Response ID 7 with none pending -> rsp_err_o=1 exactly one cycle, count_o unchanged.
REQ-036 Alloc/respond/pop 20 transactions through CAPACITY=8 -> pointer wrap, data in issue order, count_o returns 0.
REQ-037 oup_ready_i=0 for 5 cycles with valid head -> oup_data_o stable; alloc and response same cycle -> count_o correct.
REQ-038 Assert rst_i asynchronously with 4 pending -> oup_valid_o=0 and count_o=0 immediately; later response -> rsp_err_o=1.
